// File: rtl/regfile_pkg.sv
// Shared widths, typedefs and pending-count update rule for the scoreboarded
// register file and its per-register counters.
package regfile_pkg;

    localparam int DEF_NREGS  = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_PEND_W = 2;
    localparam int DEF_AW     = $clog2(DEF_NREGS);

    typedef logic [DEF_AW-1:0]     regaddr_t;
    typedef logic [DEF_DATA_W-1:0] regval_t;

    // Issue and writeback on the same register cancel out. The increment
    // never exceeds the maximum because issue is held off at a full count.
    function automatic int unsigned next_pend(input int unsigned count,
                                              input logic        inc,
                                              input logic        dec);
        if (inc && !dec) begin
            return count + 1;
        end
        if (dec && !inc) begin
            return (count == 0) ? 0 : count - 1;
        end
        return count;
    endfunction

endpackage

// File: rtl/scoreboard_regfile_pend_counter.sv
// One register's outstanding-write counter with full and empty flags.
module pend_counter
    import regfile_pkg::*;
#(
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [PEND_W-1:0] count_o,
    output logic              is_max_o,
    output logic              is_zero_o
);

    logic [PEND_W-1:0] count_q;
    logic [PEND_W-1:0] count_d;

    always_comb begin
        count_d = PEND_W'(next_pend(32'(count_q), inc_i, dec_i));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign is_max_o  = (count_q == {PEND_W{1'b1}});
    assign is_zero_o = (count_q == '0);

endmodule

// File: rtl/scoreboard_regfile.sv
// Register file with per-register pending-write counters, bypassed
// combinational read ports and an issue-side stall on a full counter.
module scoreboard_regfile
    import regfile_pkg::*;
#(
    parameter int NREGS    = DEF_NREGS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NREAD    = 2,
    parameter int PEND_W   = DEF_PEND_W,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*AW-1:0]     rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_inuse,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_dest,
    output logic                    issue_ready,
    input  logic                    wb_valid,
    input  logic [AW-1:0]           wb_dest,
    input  logic [DATA_W-1:0]       wb_data,
    output logic                    wb_done,
    output logic                    wb_err
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [PEND_W-1:0] pend_cnt [NREGS];
    logic [NREGS-1:0]  pend_max;
    logic [NREGS-1:0]  pend_zero;
    logic              wb_done_q;
    logic              wb_err_q;
    logic              wb_err_d;
    logic              wb_zero;
    logic              issue_fire;

    assign wb_zero     = (ZERO_REG != 0) && (wb_dest == '0);
    // A writeback landing on a full register this cycle frees a slot for issue.
    assign issue_ready = !(pend_max[issue_dest] && !(wb_valid && (wb_dest == issue_dest)));
    assign issue_fire  = issue_valid && issue_ready;
    assign wb_err_d    = wb_err_q | (wb_valid && pend_zero[wb_dest] && !wb_zero);

    for (genvar g = 0; g < NREGS; g++) begin : g_pend
        logic inc;
        logic dec;
        // Hardwired zero register never accumulates a count.
        assign inc = issue_fire && (issue_dest == AW'(g)) && !((ZERO_REG != 0) && (g == 0));
        assign dec = wb_valid && (wb_dest == AW'(g)) && !((ZERO_REG != 0) && (g == 0));

        pend_counter #(.PEND_W(PEND_W)) u_pend (
            .clk       (clk),
            .rst       (rst),
            .inc_i     (inc),
            .dec_i     (dec),
            .count_o   (pend_cnt[g]),
            .is_max_o  (pend_max[g]),
            .is_zero_o (pend_zero[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            wb_done_q <= 1'b0;
            wb_err_q  <= 1'b0;
        end else begin
            if (wb_valid && !wb_zero) begin
                regs_q[wb_dest] <= wb_data;
            end
            wb_done_q <= wb_valid;
            wb_err_q  <= wb_err_d;
        end
    end

    assign wb_done = wb_done_q;
    assign wb_err  = wb_err_q;

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit;
        logic          zr;
        assign addr = rd_addr[p*AW +: AW];
        assign hit  = wb_valid && (wb_dest == addr);
        assign zr   = (ZERO_REG != 0) && (addr == '0);
        assign rd_data[p*DATA_W +: DATA_W] = zr ? '0 : (hit ? wb_data : regs_q[addr]);
        // The last outstanding write completing this cycle already clears inuse.
        assign rd_inuse[p] = !zr && !pend_zero[addr]
                             && !(hit && (pend_cnt[addr] == PEND_W'(1)));
    end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed and random checks of two register file instances (plain and
// hardwired-zero) against an array-based model of the register file rules.
module tb_scoreboard_regfile;
    import regfile_pkg::*;

    localparam int NR   = 16;
    localparam int DW   = 16;
    localparam int NRD  = 2;
    localparam int AW   = 4;
    localparam int PMAX = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NRD*AW-1:0] rd_addr = '0;
    logic              issue_valid = 1'b0;
    logic [AW-1:0]     issue_dest = '0;
    logic              wb_valid = 1'b0;
    logic [AW-1:0]     wb_dest = '0;
    logic [DW-1:0]     wb_data = '0;

    logic [NRD*DW-1:0] rd_data  [2];
    logic [NRD-1:0]    rd_inuse [2];
    logic              issue_ready [2];
    logic              wb_done [2];
    logic              wb_err [2];

    int checks = 0;
    int failures = 0;

    int      m_pend [2][NR];
    regval_t m_reg  [2][NR];
    logic    m_err  [2];
    logic    m_done [2];

    always #5 clk = ~clk;

    scoreboard_regfile #(.NREGS(NR), .DATA_W(DW), .NREAD(NRD), .PEND_W(2), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data[0]), .rd_inuse(rd_inuse[0]),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready[0]),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
        .wb_done(wb_done[0]), .wb_err(wb_err[0]));

    scoreboard_regfile #(.NREGS(NR), .DATA_W(DW), .NREAD(NRD), .PEND_W(2), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data[1]), .rd_inuse(rd_inuse[1]),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready[1]),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
        .wb_done(wb_done[1]), .wb_err(wb_err[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_zr(input int k, input int a);
        return (k == 1) && (a == 0);
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int k, input int a);
        if (is_zr(k, a)) return '0;
        if (wb_valid && int'(wb_dest) == a) return wb_data;
        return m_reg[k][a];
    endfunction

    function automatic logic exp_inuse(input int k, input int a);
        if (is_zr(k, a)) return 1'b0;
        if (m_pend[k][a] == 0) return 1'b0;
        if (wb_valid && int'(wb_dest) == a && m_pend[k][a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_ready(input int k);
        return !(m_pend[k][issue_dest] == PMAX && !(wb_valid && wb_dest == issue_dest));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < NR; r++) begin
                m_pend[k][r] = 0;
                m_reg[k][r]  = '0;
            end
            m_err[k]  = 1'b0;
            m_done[k] = 1'b0;
        end
    endtask

    task automatic drive(input logic iv, input int id, input logic wv, input int wd,
                         input logic [DW-1:0] wdat, input int ra0, input int ra1);
        issue_valid = iv;
        issue_dest  = AW'(id);
        wb_valid    = wv;
        wb_dest     = AW'(wd);
        wb_data     = wdat;
        rd_addr     = {AW'(ra1), AW'(ra0)};
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < NRD; p++) begin
                int a;
                a = int'(rd_addr[p*AW +: AW]);
                chk($sformatf("rd_data%0d_i%0d_a%0d", p, k, a), 32'(rd_data[k][p*DW +: DW]), 32'(exp_rd(k, a)));
                chk($sformatf("rd_inuse%0d_i%0d_a%0d", p, k, a), 32'(rd_inuse[k][p]), 32'(exp_inuse(k, a)));
            end
            chk($sformatf("issue_ready_i%0d", k), 32'(issue_ready[k]), 32'(exp_ready(k)));
            chk($sformatf("wb_done_i%0d", k), 32'(wb_done[k]), 32'(m_done[k]));
            chk($sformatf("wb_err_i%0d", k), 32'(wb_err[k]), 32'(m_err[k]));
        end
    endtask

    task automatic tick();
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                logic fire;
                int   wd;
                int   id;
                fire = issue_valid && exp_ready(k);
                wd   = int'(wb_dest);
                id   = int'(issue_dest);
                if (wb_valid && !is_zr(k, wd)) begin
                    if (m_pend[k][wd] == 0) m_err[k] = 1'b1;
                    m_reg[k][wd] = wb_data;
                end
                for (int r = 0; r < NR; r++) begin
                    logic inc;
                    logic dec;
                    inc = fire && id == r && !is_zr(k, r);
                    dec = wb_valid && wd == r && !is_zr(k, r);
                    if (inc && !dec) m_pend[k][r]++;
                    else if (dec && !inc && m_pend[k][r] > 0) m_pend[k][r]--;
                end
                m_done[k] = wb_valid;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int ra0, input int ra1);
        drive(1'b0, 0, 1'b0, 0, '0, ra0, ra1);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reset state across all registers on both ports.
        for (int a = 0; a < NR; a++) begin
            idle(a, NR - 1 - a);
            tick();
        end
        idle(0, 0);
        chk("reset_issue_ready", 32'(issue_ready[0]), 32'd1);
        chk("reset_wb_err", 32'(wb_err[0]), 32'd0);
        tick();

        // Issue then writeback to reg 5 with bypass.
        drive(1'b1, 5, 1'b0, 0, '0, 5, 5);
        tick();
        idle(5, 5);
        chk("r5_inuse_pending", 32'(rd_inuse[0][0]), 32'd1);
        tick();
        drive(1'b0, 0, 1'b1, 5, 16'hBEEF, 5, 5);
        chk("r5_bypass_data", 32'(rd_data[0][DW-1:0]), 32'hBEEF);
        chk("r5_bypass_inuse", 32'(rd_inuse[0][0]), 32'd0);
        tick();
        idle(5, 5);
        chk("r5_stored", 32'(rd_data[0][DW-1:0]), 32'hBEEF);
        chk("r5_wb_done_pulse", 32'(wb_done[0]), 32'd1);
        tick();
        idle(5, 5);
        chk("r5_wb_done_clear", 32'(wb_done[0]), 32'd0);
        tick();

        // Saturate reg 3, then issue alongside a writeback to it.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3, 1'b0, 0, '0, 3, 3);
            tick();
        end
        drive(1'b1, 3, 1'b0, 0, '0, 3, 3);
        chk("r3_full_stall", 32'(issue_ready[0]), 32'd0);
        tick();
        drive(1'b1, 3, 1'b1, 3, 16'h0033, 3, 3);
        chk("r3_full_wb_ready", 32'(issue_ready[0]), 32'd1);
        tick();
        idle(3, 3);
        chk("r3_still_full", 32'(issue_ready[0]), 32'd1);
        tick();
        drive(1'b1, 3, 1'b0, 0, '0, 3, 3);
        chk("r3_count_kept", 32'(issue_ready[0]), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 0, 1'b1, 3, 16'(16'h0100 + i), 3, 3);
            tick();
        end
        idle(3, 3);
        chk("r3_drained", 32'(rd_inuse[0][0]), 32'd0);
        chk("r3_no_err", 32'(wb_err[0]), 32'd0);
        tick();

        // Simultaneous issue to 7 and writeback to 2.
        drive(1'b1, 2, 1'b0, 0, '0, 2, 7);
        tick();
        drive(1'b1, 7, 1'b1, 2, 16'hA5A5, 7, 2);
        tick();
        idle(7, 2);
        chk("r7_pending", 32'(rd_inuse[0][0]), 32'd1);
        chk("r2_clear", 32'(rd_inuse[0][1]), 32'd0);
        chk("r2_data", 32'(rd_data[0][2*DW-1:DW]), 32'hA5A5);
        tick();

        // Underflow to reg 9, sticky error, then async reset mid-cycle.
        drive(1'b0, 0, 1'b1, 9, 16'h1234, 9, 7);
        tick();
        idle(9, 7);
        chk("r9_data", 32'(rd_data[0][DW-1:0]), 32'h1234);
        chk("r9_err_set", 32'(wb_err[0]), 32'd1);
        tick();
        drive(1'b0, 0, 1'b1, 5, 16'h0055, 9, 7);
        tick();
        idle(9, 7);
        chk("err_sticky", 32'(wb_err[0]), 32'd1);
        chk("done_before_rst", 32'(wb_done[0]), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_async_data_i%0d", k), 32'(rd_data[k]), 32'd0);
            chk($sformatf("rst_async_inuse_i%0d", k), 32'(rd_inuse[k]), 32'd0);
            chk($sformatf("rst_async_err_i%0d", k), 32'(wb_err[k]), 32'd0);
            chk($sformatf("rst_async_done_i%0d", k), 32'(wb_done[k]), 32'd0);
            chk($sformatf("rst_async_ready_i%0d", k), 32'(issue_ready[k]), 32'd1);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Register 0 on both instances.
        drive(1'b1, 0, 1'b0, 0, '0, 0, 0);
        tick();
        drive(1'b0, 0, 1'b1, 0, 16'hFFFF, 0, 0);
        chk("z_bypass_zero", 32'(rd_data[1][DW-1:0]), 32'h0);
        chk("z_inuse_zero", 32'(rd_inuse[1][0]), 32'd0);
        chk("nz_bypass", 32'(rd_data[0][DW-1:0]), 32'hFFFF);
        tick();
        idle(0, 0);
        chk("z_wb_done", 32'(wb_done[1]), 32'd1);
        chk("z_wb_err", 32'(wb_err[1]), 32'd0);
        chk("z_read_zero", 32'(rd_data[1][DW-1:0]), 32'h0);
        chk("nz_read", 32'(rd_data[0][DW-1:0]), 32'hFFFF);
        tick();

        // Random traffic, biased toward a few registers to reach full counts.
        for (int i = 0; i < 400; i++) begin
            int id;
            int wd;
            id = ($urandom % 2) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, NR - 1));
            wd = ($urandom % 2) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, NR - 1));
            drive(1'($urandom % 4 != 0), id, 1'($urandom % 3 == 0), wd, 16'($urandom),
                  int'($urandom_range(0, NR - 1)), ($urandom % 2) ? id : wd);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scoreboard_regfile.md
Name: scoreboard_regfile

Overview:
Parametrised successor to the pipeline's 16x16 register file with single inuse bits. Holds NREGS architectural registers and a per-register pending-write counter, so a destination can have several outstanding writes. Supports NREAD combinational read ports with writeback bypass and an issue-side stall. Sits between Decode (reads and issue) and Execute (writeback).

Parameters:
NREGS, 16, number of registers (power of two, >=2)
DATA_W, 16, register width in bits
NREAD, 2, number of read ports
PEND_W, 2, pending-counter width; max outstanding writes per register = 2^PEND_W-1
ZERO_REG, 0, 1 = register 0 hardwired to zero
(AW = $clog2(NREGS), derived localparam)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous active-low reset
rd_addr  in  NREAD*AW  read addresses, port i at [i*AW +: AW]
rd_data  out  NREAD*DATA_W  read data per port
rd_inuse  out  NREAD  1 = register still has pending writes
issue_valid  in  1  Decode issues an instruction writing issue_dest
issue_dest  in  AW  destination of the issued instruction
issue_ready  out  1  issue accepted this cycle when high
wb_valid  in  1  Execute writeback strobe (storeNow)
wb_dest  in  AW  writeback register
wb_data  in  DATA_W  writeback value
wb_done  out  1  one-cycle acknowledge (storeDone)
wb_err  out  1  sticky: writeback to a register with zero pending count

Behaviour:
- Reset (rst=0, async): all regs 0, all pend counts 0, wb_done=0, wb_err=0.
- Reads are combinational, 0 cycles.
  - rd_data[i] = wb_data if wb_valid && wb_dest==rd_addr[i], else reg[rd_addr[i]] (bypass).
  - rd_inuse[i] = pend[a]!=0 && !(wb_valid && wb_dest==a && pend[a]==1).
- issue_ready is combinational: low only when pend[issue_dest]==MAX and no same-cycle wb_valid to issue_dest.
- Issue fires when issue_valid && issue_ready.
- Per-register count update at posedge:
  - issue fire only: +1.
  - wb_valid only: -1, floored at 0.
  - both on the same register: unchanged.
  - Issue and wb on different registers update independently.
- Writeback: reg[wb_dest] <= wb_data at posedge. Applied even when the count is 0.
- Underflow: if the count is 0 at wb, wb_err <= 1 and the count stays 0. wb_err clears only on reset.
- wb_done <= wb_valid. Registered, so it pulses the cycle after the strobe. Back-to-back wb_valid gives back-to-back wb_done.
- ZERO_REG=1 (register 0):
  - Reads return 0 and rd_inuse=0.
  - Writes are dropped.
  - Issue to reg 0 is always ready and leaves no count.
  - wb to reg 0 never sets wb_err.
  - wb_done still pulses.
- Reset asserted mid-operation clears counts and data immediately. Pending writebacks after reset raise wb_err.
- No X on outputs for any in-range address. Out-of-range addresses are impossible because NREGS is a power of two.

Decomposition:
- Shared package regfile_pkg holds:
  - default widths (DATA_W, NREGS, PEND_W);
  - the regaddr_t/regval_t typedefs parametrised via localparams;
  - the function next_pend(count, inc, dec) implementing the saturating up/down rule.
- One natural sub-module: pend_counter (a single register's PEND_W-bit up/down counter with max/zero flags), instantiated NREGS times by generate.
- Read muxes and bypass stay in the top module.

Test Plan:
- Reset then read all regs on both ports -> rd_data=0, rd_inuse=0, issue_ready=1, wb_err=0.
- Issue dest=5, next cycle wb dest=5 data=16'hBEEF -> rd_inuse=1 between the two; during the wb cycle rd_data=BEEF (bypass) and rd_inuse=0; afterwards reg5=BEEF and wb_done pulses one cycle after wb_valid.
- PEND_W=2: issue dest=3 three times -> issue_ready=0 for dest 3. Same cycle as a 4th issue, wb dest=3 -> issue_ready=1 and the count stays 3; three further wbs -> rd_inuse=0.
- Simultaneous issue dest=7 and wb dest=2 (count 1) -> pend[7]=1, pend[2]=0, reg2 updated.
- wb dest=9 with count 0, data=16'h1234 -> reg9=1234, wb_err=1 and stays 1 until rst low; async reset mid-stream -> all outputs to reset values without a clock edge.
- ZERO_REG=1: issue dest=0, wb dest=0 data=16'hFFFF -> reads of reg 0 return 0, rd_inuse=0, wb_err=0, wb_done=1 next cycle.
